// File: rtl/nbit_serializer_pkg.sv
// Shared types and sizing helpers for the N-bit serializer.
package nbit_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbit_bit_counter.sv
// Frame bit counter: clears on a new or finished frame, flags the final bit.
module nbit_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_last = (count == term);

endmodule

// File: rtl/nbit_serializer.sv
// LSB-first parallel-to-serial converter with gapless back-to-back loads.
// Define NBIT_SERIALIZER_PARITY_EN to append an even parity bit per frame.
module nbit_serializer
  import nbit_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] D,
  input  logic         shift_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last
);

`ifdef NBIT_SERIALIZER_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] TERM = CW'(F - 1);

  state_t state, state_nxt;
  logic [F-1:0] sreg;
  logic [CW-1:0] cnt;
  logic at_last;
  logic fire, adv, done;

  assign ser_valid  = (state == S_SHIFT);
  assign ser_last   = ser_valid & at_last;
  assign ser_out    = ser_valid & sreg[0];
  assign done       = ser_last & shift_en;
  assign adv        = ser_valid & shift_en & (cnt != TERM);
  assign load_ready = ~ser_valid | done;
  assign fire       = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (fire) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (done) state_nxt = fire ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Parity rides in the top bit of sreg so it falls out after the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (fire) begin
`ifdef NBIT_SERIALIZER_PARITY_EN
      sreg <= {^D, D};
`else
      sreg <= D;
`endif
    end else if (adv) begin
      sreg <= {1'b0, sreg[F-1:1]};
    end
  end

  nbit_bit_counter #(
    .W(CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (fire | done),
    .inc    (adv),
    .term   (TERM),
    .count  (cnt),
    .at_last(at_last)
  );

endmodule
